// File: rtl/udma_rx_byte_packer_pkg.sv
// Shared types and constants for the uDMA RX byte packer.
// Beat size encoding follows the uDMA RX channel datasize field.
package udma_rx_byte_packer_pkg;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } pk_state_e;

  localparam logic [1:0] DSIZE_BYTE = 2'd0;
  localparam logic [1:0] DSIZE_HALF = 2'd1;
  localparam logic [1:0] DSIZE_WORD = 2'd2;

endpackage

// File: rtl/udma_rx_byte_packer_if.sv
// Byte-in / beat-out handshake bundle of the RX packer.
// master = packer side, slave = peripheral + RX channel mux side.
interface udma_rx_byte_packer_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        ch_valid;
  logic [31:0] ch_data;
  logic [1:0]  ch_datasize;
  logic        ch_ready;

  modport master (
    input  in_valid, in_data, ch_ready,
    output in_ready, ch_valid, ch_data, ch_datasize
  );

  modport slave (
    output in_valid, in_data, ch_ready,
    input  in_ready, ch_valid, ch_data, ch_datasize
  );
endinterface

// File: rtl/udma_rx_byte_packer_timer.sv
// Idle timer: down-counter reloaded with the threshold whenever not running,
// terminal count (1) on a running cycle flags the timeout.
module udma_rx_byte_packer_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             i_clr,
  input  logic             i_run,
  input  logic [WIDTH-1:0] i_threshold,
  output logic             o_hit
);

  logic [WIDTH-1:0] r_tmr;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_tmr <= '0;
    end else if (i_clr || !i_run) begin
      r_tmr <= i_threshold;
    end else if (r_tmr != '0) begin
      r_tmr <= r_tmr - 1'b1;
    end
  end

  // threshold 0 disables the timeout entirely
  assign o_hit = i_run && !i_clr && (i_threshold != '0) && (r_tmr == WIDTH'(1));

endmodule

// File: rtl/udma_rx_byte_packer.sv
// Packs an 8-bit RX byte stream into byte/half/word beats for one uDMA RX channel,
// never letting a beat span two transfers; partials flushed on end, flush or idle timeout.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_FILL  | accepting bytes into r_buf while r_left != 0 and r_cnt < 4
// ST_DRAIN | moving r_buf into the output beat register, chunk by chunk
module udma_rx_byte_packer
  import udma_rx_byte_packer_pkg::*;
#(
  parameter int TRANS_SIZE    = 16,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     cfg_start_i,
  input  logic [TRANS_SIZE-1:0]    cfg_size_i,
  input  logic                     cfg_continuous_i,
  input  logic                     cfg_clr_i,
  input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout_i,
  input  logic                     flush_i,
  udma_rx_byte_packer_if.master    bus,
  output logic                     busy_o,
  output logic                     timeout_evt_o
);

  pk_state_e             r_state;
  logic [31:0]           r_buf;
  logic [2:0]            r_cnt;
  logic [TRANS_SIZE-1:0] r_left;
  logic                  r_out_valid;
  logic [31:0]           r_out_data;
  logic [1:0]            r_out_size;
  logic                  r_evt;

  logic                  w_in_ready;
  logic                  w_accept;
  logic [2:0]            w_cnt_acc;
  logic [31:0]           w_buf_acc;
  logic                  w_last;
  logic [TRANS_SIZE-1:0] w_left_nxt;
  logic                  w_idle_run;
  logic                  w_tmo_hit;
  logic                  w_trigger;
  logic                  w_load;
  logic [31:0]           w_chunk_data;
  logic [1:0]            w_chunk_size;

  assign w_in_ready = (r_state == ST_FILL) && (r_left != '0) && (r_cnt < 3'd4) && !cfg_clr_i;
  assign w_accept   = w_in_ready && bus.in_valid;
  assign w_cnt_acc  = r_cnt + 3'(w_accept);
  assign w_last     = w_accept && (r_left == TRANS_SIZE'(1));
  assign w_idle_run = (r_state == ST_FILL) && (r_cnt != 3'd0) && !w_accept;
  assign w_load     = (r_state == ST_DRAIN) && (!r_out_valid || bus.ch_ready);

  always_comb begin
    w_buf_acc = r_buf;
    if (w_accept) w_buf_acc[{r_cnt[1:0], 3'b000} +: 8] = bus.in_data;
  end

  // a new start always wins; continuous mode reloads on the last byte
  always_comb begin
    w_left_nxt = r_left - TRANS_SIZE'(w_accept);
    if (cfg_start_i)                       w_left_nxt = cfg_size_i;
    else if (w_last && cfg_continuous_i)   w_left_nxt = cfg_size_i;
  end

  // w_last keeps a reloaded transfer from merging into the previous beat
  assign w_trigger = (r_state == ST_FILL) &&
                     ((w_cnt_acc == 3'd4) ||
                      ((w_cnt_acc != 3'd0) &&
                       ((w_left_nxt == '0) || w_last || flush_i || w_tmo_hit)));

  always_comb begin
    w_chunk_data = {24'h0, r_buf[7:0]};
    w_chunk_size = DSIZE_BYTE;
    case (r_cnt)
      3'd4: begin
        w_chunk_data = r_buf;
        w_chunk_size = DSIZE_WORD;
      end
      3'd3, 3'd2: begin
        w_chunk_data = {16'h0, r_buf[15:0]};
        w_chunk_size = DSIZE_HALF;
      end
      default: ;
    endcase
  end

  udma_rx_byte_packer_timer #(
    .WIDTH (TIMEOUT_WIDTH)
  ) u_timer (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .i_clr       (cfg_clr_i),
    .i_run       (w_idle_run),
    .i_threshold (cfg_timeout_i),
    .o_hit       (w_tmo_hit)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= ST_FILL;
      r_buf       <= '0;
      r_cnt       <= '0;
      r_left      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_size  <= DSIZE_BYTE;
      r_evt       <= 1'b0;
    end else if (cfg_clr_i) begin
      r_state     <= ST_FILL;
      r_buf       <= '0;
      r_cnt       <= '0;
      r_left      <= '0;
      r_out_valid <= 1'b0;
      r_evt       <= 1'b0;
    end else begin
      r_evt  <= w_tmo_hit && w_trigger;
      r_left <= w_left_nxt;

      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_chunk_data;
        r_out_size  <= w_chunk_size;
      end else if (bus.ch_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        ST_FILL: begin
          r_buf <= w_buf_acc;
          r_cnt <= w_cnt_acc;
          if (w_trigger) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_load) begin
            // three bytes go out as half then byte, lane 2 shifted down to [7:0]
            if (r_cnt == 3'd3) begin
              r_buf <= {16'h0, r_buf[31:16]};
              r_cnt <= 3'd1;
            end else begin
              r_buf   <= '0;
              r_cnt   <= 3'd0;
              r_state <= ST_FILL;
            end
          end
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.ch_valid    = r_out_valid;
  assign bus.ch_data     = r_out_data;
  assign bus.ch_datasize = r_out_size;
  assign busy_o          = (r_left != '0) || (r_cnt != 3'd0) || r_out_valid;
  assign timeout_evt_o   = r_evt;

endmodule

// File: tb/tb_udma_rx_byte_packer.sv
// Self-checking bench for udma_rx_byte_packer: vector table, hand-written
// corner sequences and randomized transfers against a transfer-level beat model.
module tb_udma_rx_byte_packer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cfg_start = 1'b0;
  logic [15:0] cfg_size = '0;
  logic        cfg_continuous = 1'b0;
  logic        cfg_clr = 1'b0;
  logic [15:0] cfg_timeout = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        timeout_evt;
  bit          rnd_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int evt_cnt = 0;
  logic [33:0] beats[$];

  udma_rx_byte_packer_if bus ();

  udma_rx_byte_packer #(
    .TRANS_SIZE    (16),
    .TIMEOUT_WIDTH (16)
  ) dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .cfg_start_i      (cfg_start),
    .cfg_size_i       (cfg_size),
    .cfg_continuous_i (cfg_continuous),
    .cfg_clr_i        (cfg_clr),
    .cfg_timeout_i    (cfg_timeout),
    .flush_i          (flush),
    .bus              (bus),
    .busy_o           (busy),
    .timeout_evt_o    (timeout_evt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rstn) begin
      if (bus.ch_valid && bus.ch_ready) beats.push_back({bus.ch_datasize, bus.ch_data});
      if (timeout_evt) evt_cnt++;
    end
  end

  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      bus.ch_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) step();
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 200) break;
    end
    if (n > 200) check("send_byte_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_beats(input string name, input int n, input int budget);
    int k = 0;
    while (beats.size() < n && k < budget) begin
      step();
      k++;
    end
    check(name, 64'(beats.size()), 64'(n));
  endtask

  task automatic pop_check(input string name, input logic [1:0] sz, input logic [31:0] d);
    logic [33:0] b;
    b = (beats.size() != 0) ? beats.pop_front() : 34'h3_FFFF_FFFF;
    check(name, 64'(b), 64'({sz, d}));
  endtask

  task automatic clear_dut();
    cfg_clr = 1'b1;
    step();
    cfg_clr = 1'b0;
    step();
    beats.delete();
  endtask

  task automatic start(input int size, input bit cont);
    cfg_size       = 16'(size);
    cfg_continuous = cont;
    cfg_start      = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  typedef struct {
    int             size;
    int             nbytes;
    logic [7:0]     base;
    bit             cont;
    int             nexp;
    logic [3:0][33:0] exp;
  } vec_t;

  vec_t vt[6];

  initial begin
    logic [7:0]  bytes[$];
    logic [33:0] exp_q[$];
    int          rem, idx, sz;
    bit          ok;
    logic        st_valid, st_ready;

    vt[0] = '{size: 8, nbytes: 8, base: 8'h01, cont: 1'b0, nexp: 2, exp: '0};
    vt[0].exp[0] = {2'd2, 32'h04030201};
    vt[0].exp[1] = {2'd2, 32'h08070605};
    vt[1] = '{size: 7, nbytes: 7, base: 8'h11, cont: 1'b0, nexp: 3, exp: '0};
    vt[1].exp[0] = {2'd2, 32'h14131211};
    vt[1].exp[1] = {2'd1, 32'h00001615};
    vt[1].exp[2] = {2'd0, 32'h00000017};
    vt[2] = '{size: 3, nbytes: 6, base: 8'h21, cont: 1'b1, nexp: 4, exp: '0};
    vt[2].exp[0] = {2'd1, 32'h00002221};
    vt[2].exp[1] = {2'd0, 32'h00000023};
    vt[2].exp[2] = {2'd1, 32'h00002524};
    vt[2].exp[3] = {2'd0, 32'h00000026};
    vt[3] = '{size: 1, nbytes: 1, base: 8'h40, cont: 1'b0, nexp: 1, exp: '0};
    vt[3].exp[0] = {2'd0, 32'h00000040};
    vt[4] = '{size: 2, nbytes: 2, base: 8'h50, cont: 1'b0, nexp: 1, exp: '0};
    vt[4].exp[0] = {2'd1, 32'h00005150};
    vt[5] = '{size: 5, nbytes: 5, base: 8'h60, cont: 1'b0, nexp: 2, exp: '0};
    vt[5].exp[0] = {2'd2, 32'h63626160};
    vt[5].exp[1] = {2'd0, 32'h00000064};

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.ch_ready = 1'b0;
    rstn = 1'b0;
    repeat (3) step();
    check("rst_ch_valid", 64'(bus.ch_valid), 64'(0));
    check("rst_ch_data", 64'(bus.ch_data), 64'(0));
    check("rst_datasize", 64'(bus.ch_datasize), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_evt", 64'(timeout_evt), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(0));
    rstn = 1'b1;
    step();

    // vector table
    for (int i = 0; i < 6; i++) begin
      clear_dut();
      bus.ch_ready = 1'b1;
      start(vt[i].size, vt[i].cont);
      for (int j = 0; j < vt[i].nbytes; j++) send_byte(vt[i].base + 8'(j), 0);
      wait_beats($sformatf("vec%0d_count", i), vt[i].nexp, 60);
      for (int k = 0; k < vt[i].nexp; k++)
        pop_check($sformatf("vec%0d_beat%0d", i, k), vt[i].exp[k][33:32], vt[i].exp[k][31:0]);
      repeat (2) step();
      check($sformatf("vec%0d_busy", i), 64'(busy), 64'(vt[i].cont));
    end
    cfg_continuous = 1'b0;

    // idle timeout flushes a partial half, then packing restarts at lane 0
    clear_dut();
    cfg_timeout  = 16'd5;
    bus.ch_ready = 1'b1;
    evt_cnt      = 0;
    start(100, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    repeat (4) step();
    check("tmo_early_beat", 64'(beats.size()), 64'(0));
    check("tmo_early_evt", 64'(timeout_evt), 64'(0));
    step();
    check("tmo_evt_pulse", 64'(timeout_evt), 64'(1));
    wait_beats("tmo_count", 1, 20);
    pop_check("tmo_half", 2'd1, 32'h0000BBAA);
    send_byte(8'hCC, 0);
    send_byte(8'hDD, 0);
    send_byte(8'hEE, 0);
    send_byte(8'hFF, 0);
    wait_beats("tmo_next_count", 1, 20);
    pop_check("tmo_next_word", 2'd2, 32'hFFEEDDCC);
    check("tmo_evt_once", 64'(evt_cnt), 64'(1));

    // explicit flush of one byte; flush on empty buffer does nothing
    clear_dut();
    cfg_timeout = 16'd0;
    start(100, 0);
    send_byte(8'h77, 0);
    repeat (8) step();
    check("flush_no_spont", 64'(beats.size()), 64'(0));
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_beats("flush_count", 1, 10);
    pop_check("flush_byte", 2'd0, 32'h00000077);
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (4) step();
    check("flush_empty_noop", 64'(beats.size()), 64'(0));
    check("flush_busy", 64'(busy), 64'(1));

    // back-pressure: word held stable, buffer fills and stalls, then both drain in order
    clear_dut();
    bus.ch_ready = 1'b0;
    start(100, 0);
    for (int j = 0; j < 8; j++) send_byte(8'hA0 + 8'(j), 0);
    step();
    check("stall_in_ready", 64'(bus.in_ready), 64'(0));
    ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (!(bus.ch_valid === 1'b1 && bus.ch_data === 32'hA3A2A1A0 &&
            bus.ch_datasize === 2'd2 && bus.in_ready === 1'b0)) ok = 1'b0;
    end
    check("stall_hold", 64'(ok), 64'(1));
    bus.ch_ready = 1'b1;
    wait_beats("stall_count", 2, 20);
    pop_check("stall_beat0", 2'd2, 32'hA3A2A1A0);
    pop_check("stall_beat1", 2'd2, 32'hA7A6A5A4);

    // clear drops a pending beat and buffered bytes
    clear_dut();
    bus.ch_ready = 1'b0;
    start(100, 0);
    for (int j = 0; j < 6; j++) send_byte(8'hC0 + 8'(j), 0);
    step();
    st_valid = bus.ch_valid;
    check("clr_pre_valid", 64'(st_valid), 64'(1));
    cfg_clr = 1'b1;
    step();
    cfg_clr = 1'b0;
    st_valid = bus.ch_valid;
    st_ready = bus.in_ready;
    check("clr_valid", 64'(st_valid), 64'(0));
    check("clr_busy", 64'(busy), 64'(0));
    check("clr_in_ready", 64'(st_ready), 64'(0));
    bus.ch_ready = 1'b1;
    repeat (5) step();
    check("clr_no_output", 64'(beats.size()), 64'(0));

    // randomized transfers vs. transfer-level beat model
    for (int t = 0; t < 25; t++) begin
      rnd_ready = 1'b0;
      step();
      clear_dut();
      bytes.delete();
      exp_q.delete();
      sz = $urandom_range(1, 24);
      for (int j = 0; j < sz; j++) bytes.push_back(8'($urandom_range(0, 255)));
      rem = sz;
      idx = 0;
      while (rem > 0) begin
        if (rem >= 4) begin
          exp_q.push_back({2'd2, bytes[idx+3], bytes[idx+2], bytes[idx+1], bytes[idx]});
          idx += 4; rem -= 4;
        end else if (rem >= 2) begin
          exp_q.push_back({2'd1, 16'h0, bytes[idx+1], bytes[idx]});
          idx += 2; rem -= 2;
        end else begin
          exp_q.push_back({2'd0, 24'h0, bytes[idx]});
          idx += 1; rem -= 1;
        end
      end
      rnd_ready = 1'b1;
      start(sz, 0);
      for (int j = 0; j < sz; j++) send_byte(bytes[j], $urandom_range(0, 2));
      begin
        int k = 0;
        while (busy && k < 300) begin
          step();
          k++;
        end
      end
      check($sformatf("rnd%0d_idle", t), 64'(busy), 64'(0));
      check($sformatf("rnd%0d_in_ready", t), 64'(bus.in_ready), 64'(0));
      check($sformatf("rnd%0d_count", t), 64'(beats.size()), 64'(exp_q.size()));
      while (exp_q.size() != 0) begin
        logic [33:0] e;
        e = exp_q.pop_front();
        pop_check($sformatf("rnd%0d_beat", t), e[33:32], e[31:0]);
      end
    end
    rnd_ready = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
